spi_flash_reader: RTL
=====================

Name: spi_flash_reader

Overview:
- Program-memory responder for the uC_8bits fetch port.
- Watches the 12-bit fetch address from the core, fetches one byte from an external SPI NOR flash with the READ command (0x03), and returns it on flash_data with flash_ready high.
- Sits between the core's flash_addr/flash_data/flash_ready port and the board SPI pins; serves both bootstrap and normal fetch without knowing which mode the core is in.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period; legal range is 1 or more.
- BASE_ADDR, 24'h000000, flash byte offset added to the core address.
- READ_CMD, 8'h03, SPI opcode shifted out first.

Ports:
- clk  input  1  system clock
- arst_n  input  1  asynchronous active-low reset
- flash_addr  input  12  byte address requested by the core
- flash_data  output  8  fetched byte; valid while flash_ready=1
- flash_ready  output  1  high when flash_data holds the byte at the current flash_addr
- spi_cs_n  output  1  flash chip select, active low
- spi_sck  output  1  SPI clock, mode 0 (idles low)
- spi_mosi  output  1  command/address serial out, MSB first
- spi_miso  input  1  data serial in

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous, active-low (arst_n).
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, flash_data=8'h00, flash_ready=0, internal latched address=0, latched-valid=0.
- Internal state: lat_addr[11:0] holds the address of the byte in flash_data. lat_valid is set when a transfer completes.
- Request detect: a fetch is needed when lat_valid=0 or flash_addr!=lat_addr.
- flash_ready is combinationally gated, so it drops in the same cycle flash_addr differs from lat_addr: flash_ready = lat_valid & (flash_addr==lat_addr) & (state==IDLE).
- FSM states: IDLE, SHIFT, CAPTURE, GAP.
- IDLE: on fetch-needed, go to SHIFT.
  - Load a 32-bit shift register with {READ_CMD, BASE_ADDR + {12'h000, flash_addr}}. The address sum is modulo 2^24.
  - Capture flash_addr into req_addr.
  - Drive spi_cs_n=0 and spi_mosi=bit31.
- SHIFT: toggle SCK every CLK_DIV clk cycles.
  - Mode 0: MISO is sampled on the SCK rising edge; MOSI advances on the SCK falling edge.
  - 40 SCK cycles: 32 out (cmd + 24-bit address), then 8 in, MSB first. MOSI=0 during the data phase.
  - After the 40th falling edge, go to CAPTURE.
- CAPTURE (1 clk): spi_cs_n=1, flash_data<=rx byte, lat_addr<=req_addr, lat_valid<=1. Go to GAP.
- GAP: hold spi_cs_n=1 for 2*CLK_DIV clk cycles (minimum CS-high time), then go to IDLE.
- Latency: with flash_addr stable, flash_ready rises 2 + 80*CLK_DIV + 2*CLK_DIV clk cycles after the first edge at which a fetch was needed. That is 166 for CLK_DIV=2.
- Address change mid-transfer: the transfer is not aborted. On completion flash_data and lat_addr update to req_addr. flash_ready stays 0 because the addresses mismatch, and a new fetch starts from IDLE after GAP.
- Address returns to lat_addr while in IDLE: flash_ready=1 immediately with no SPI activity (single-entry cache hit).
- Stable address: no repeated SPI traffic; spi_cs_n stays 1.
- Address wrap: flash_addr 12'hFFF is legal. BASE_ADDR + 12'hFFF wraps within 24 bits.
- Reset asserted mid-transfer: all outputs return to reset values asynchronously; spi_cs_n goes high at once.
- After reset release: the first rising edge sees lat_valid=0, so address flash_addr is fetched.
- flash_data holds its last value while flash_ready=0.

Test Plan:
- Reset, flash_addr=0, flash model byte0=8'hA5, CLK_DIV=2 -> MOSI shows 8'h03 then 24'h000000; flash_ready rises 166 cycles after release; flash_data=8'hA5.
- flash_addr 0->12'h123, byte 0x123=8'h3C -> flash_ready drops same cycle; MOSI address 24'h000123; flash_ready=1 with 8'h3C; exactly 40 SCK pulses.
- BASE_ADDR=24'hFFF800, flash_addr=12'hFFF -> transmitted address 24'h0007FF (wrap); data from that location returned.
- Change flash_addr 5->6 at SCK pulse 20 of the 5 fetch -> one full transfer for 5 completes with flash_ready=0; GAP of 4 clks with cs_n=1; second transfer for 6; flash_ready=1 with byte 6.
- Hold flash_addr for 500 cycles after ready -> spi_cs_n remains 1, no SCK edges, flash_ready stays 1.
- Pulse arst_n low at SCK pulse 10 -> cs_n=1, sck=0, flash_ready=0, flash_data=0 immediately; a fresh fetch starts after release.

Source files
------------

// File: rtl/spi_flash_reader.sv
// -----------------------------------------------------------------------------
// spi_flash_reader
//
// Program-memory responder for the uC_8bits fetch port. Whenever the core
// presents an address whose byte is not already held, one byte is read from
// an external SPI NOR flash with a single READ transaction (SPI mode 0).
// The last fetched byte and its address are kept as a one-entry cache, so a
// stable address causes no further SPI traffic.
//
// Parameters
//   CLK_DIV   : clk cycles per SCK half-period (>= 1)
//   BASE_ADDR : flash byte offset added to the core address (sum wraps at 2^24)
//   READ_CMD  : SPI opcode sent before the 24-bit address
//
// Ports
//   clk         : system clock
//   arst_n      : asynchronous active-low reset
//   flash_addr  : byte address requested by the core
//   flash_data  : fetched byte, valid while flash_ready=1
//   flash_ready : flash_data holds the byte at the current flash_addr
//   spi_cs_n    : flash chip select, active low
//   spi_sck     : SPI clock, idles low
//   spi_mosi    : command/address serial out, MSB first
//   spi_miso    : data serial in
// -----------------------------------------------------------------------------
module spi_flash_reader #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter logic [7:0]  READ_CMD  = 8'h03
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [11:0] flash_addr,
  output logic [7:0]  flash_data,
  output logic        flash_ready,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_GAP
  } state_t;

  // One counter serves both the SCK half-period and the CS-high gap.
  localparam int unsigned    CNT_W     = $clog2(2 * CLK_DIV + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
  // 32 command/address bits followed by 8 data bits.
  localparam logic [5:0]     LAST_BIT  = 6'd39;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_bit_cnt;
  logic [31:0]      r_shift;
  logic [7:0]       r_rx;
  logic [11:0]      r_req_addr;
  logic [11:0]      r_lat_addr;
  logic             r_lat_valid;
  logic [7:0]       r_data;
  logic             r_cs_n;
  logic             r_sck;
  logic             r_mosi;

  logic             w_need;
  logic [23:0]      w_flash_addr;
  logic [31:0]      w_cmd_word;

  assign w_need       = !r_lat_valid || (flash_addr != r_lat_addr);
  // Flash offset wraps naturally in 24 bits.
  assign w_flash_addr = BASE_ADDR + {12'h000, flash_addr};
  assign w_cmd_word   = {READ_CMD, w_flash_addr};

  // Combinational on purpose: ready must drop in the very cycle the core
  // moves to a different address, before any clock edge.
  assign flash_ready = r_lat_valid && (flash_addr == r_lat_addr) && (r_state == ST_IDLE);
  assign flash_data  = r_data;
  assign spi_cs_n    = r_cs_n;
  assign spi_sck     = r_sck;
  assign spi_mosi    = r_mosi;

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values; blocking here would chain updates
  // within one edge and break the SCK/MOSI/MISO phase relationship.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_req_addr  <= '0;
      r_lat_addr  <= '0;
      r_lat_valid <= 1'b0;
      r_data      <= '0;
      r_cs_n      <= 1'b1;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_need) begin
            r_shift    <= w_cmd_word;
            r_req_addr <= flash_addr;
            r_cs_n     <= 1'b0;
            r_mosi     <= w_cmd_word[31];
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_state    <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (!r_sck) begin
              // Rising edge: sample MISO. Command-phase samples are shifted
              // out of the top and only the last 8 remain.
              r_sck <= 1'b1;
              r_rx  <= {r_rx[6:0], spi_miso};
            end else begin
              // Falling edge: advance MOSI. Zeros refill the shift register,
              // so MOSI is low through the data phase.
              r_sck <= 1'b0;
              if (r_bit_cnt == LAST_BIT) begin
                r_cs_n  <= 1'b1;
                r_mosi  <= 1'b0;
                r_state <= ST_CAPTURE;
              end else begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
                r_shift   <= {r_shift[30:0], 1'b0};
                r_mosi    <= r_shift[30];
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_CAPTURE: begin
          // The byte is tagged with the address it was fetched for, which
          // may differ from flash_addr if the core moved mid-transfer.
          r_data      <= r_rx;
          r_lat_addr  <= r_req_addr;
          r_lat_valid <= 1'b1;
          r_cnt       <= '0;
          r_state     <= ST_GAP;
        end

        ST_GAP: begin
          // Minimum CS-high time before another transaction may start.
          if (r_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
